// File: rtl/nibble_pkg.sv
// nibble_pkg: shared types, default width and bit placement helper for nibble_deser
package nibble_pkg;
  localparam int W_DEF = 4;
  typedef enum logic [1:0] {S_IDLE, S_SHIFT, S_PAR} state_t;
  function automatic int bit_pos(input int idx, input bit msb_1st, input int w = W_DEF);
    return msb_1st ? w - 1 - idx : idx;
  endfunction
endpackage

// File: rtl/nibble_shift.sv
// nibble_shift: shift register, bit counter and start-of-word abort for nibble_deser
module nibble_shift import nibble_pkg::*; #(
  parameter int W = W_DEF,
  parameter bit MSB_1ST = 1'b0,
  parameter int NB = W
) (
  input  logic                    i_clk,
  input  logic                    i_rst,
  input  logic                    i_acc,
  input  logic                    i_bit,
  input  logic                    i_sof,
  output logic [W-1:0]            o_word,
  output logic [$clog2(NB)-1:0]   o_cnt,
  output logic                    o_done,
  output logic                    o_abort
);
  localparam int CW = $clog2(NB);
  logic [W-1:0] sr_q, sr_d, base, m;
  logic [CW-1:0] cnt_q, cnt_d, idx;
  logic restart;
  // place the accepted bit; a sof on a partial word restarts at bit 0, positions >= W (parity) are not stored
  always_comb begin
    restart = i_sof && cnt_q != '0;
    idx = restart ? '0 : cnt_q;
    o_abort = i_acc && restart;
    o_done = i_acc && !restart && cnt_q == CW'(NB - 1);
    base = idx == '0 ? '0 : sr_q;
    m = int'(idx) < W ? W'(1) << bit_pos(int'(idx), MSB_1ST, W) : '0;
    sr_d = i_acc ? (base & ~m) | ({W{i_bit}} & m) : sr_q;
    cnt_d = !i_acc ? cnt_q : o_done ? '0 : idx + 1'b1;
  end
  // shift register and bit counter
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      sr_q <= '0;
      cnt_q <= '0;
    end else begin
      sr_q <= sr_d;
      cnt_q <= cnt_d;
    end
  end
  assign o_word = sr_d;
  assign o_cnt = cnt_q;
endmodule

// File: rtl/nibble_deser.sv
// nibble_deser: serial-to-parallel word assembler with held capture strobe; parity option NIBBLE_DESER_PARITY_EN
module nibble_deser import nibble_pkg::*; #(
  parameter int W = W_DEF,
  parameter bit MSB_1ST = 1'b0,
  parameter int CNT_W = 8
) (
  input  logic             i_clk,
  input  logic             i_rst,
  input  logic             i_bit_valid,
  output logic             o_bit_ready,
  input  logic             i_bit,
  input  logic             i_sof,
  input  logic             i_hold,
  output logic [W-1:0]     o_a,
  output logic             o_en,
  output logic             o_drop,
  output logic             o_perr,
  output logic [CNT_W-1:0] o_words
);
`ifdef NIBBLE_DESER_PARITY_EN
  localparam bit PAR_EN = 1'b1;
`else
  localparam bit PAR_EN = 1'b0;
`endif
  localparam int NB = PAR_EN ? W + 1 : W;
  localparam int CW = $clog2(NB);
  state_t state_q, state_d;
  logic [W-1:0] word, a_q, a_d;
  logic [CW-1:0] cnt;
  logic [CNT_W-1:0] words_q, words_d;
  logic acc, done, abort, par_ok, last, complete, strobe;
  logic pend_q, pend_d, en_q, en_d, drop_q, drop_d, perr_q, perr_d;
  nibble_shift #(.W(W), .MSB_1ST(MSB_1ST), .NB(NB)) u_shift (
    .i_clk(i_clk), .i_rst(i_rst), .i_acc(acc), .i_bit(i_bit), .i_sof(i_sof),
    .o_word(word), .o_cnt(cnt), .o_done(done), .o_abort(abort)
  );
`ifdef NIBBLE_DESER_PARITY_EN
  assign par_ok = ~(^{word, i_bit});
`else
  assign par_ok = 1'b1;
`endif
  assign last = cnt == CW'(W - 1);
  assign o_bit_ready = !(pend_q && (PAR_EN ? state_q == S_PAR : (state_q == S_SHIFT && last)));
  assign acc = i_bit_valid && o_bit_ready;
  // word position FSM: idle, collecting data, awaiting parity
  always_comb begin
    state_d = state_q;
    if (acc)
      unique case (state_q)
        S_IDLE:  state_d = S_SHIFT;
        S_SHIFT: state_d = (!i_sof && last) ? (PAR_EN ? S_PAR : S_IDLE) : S_SHIFT;
        S_PAR:   state_d = i_sof ? S_SHIFT : S_IDLE;
        default: state_d = S_IDLE;
      endcase
  end
  // a completed word is held in o_a until strobed; completion cannot coincide with pend
  always_comb begin
    complete = done && par_ok;
    strobe = pend_q && !i_hold;
    en_d = strobe;
    pend_d = complete || (pend_q && !strobe);
    a_d = complete ? word : a_q;
    words_d = words_q + CNT_W'(strobe);
    drop_d = abort;
    perr_d = done && !par_ok;
  end
  // output and handshake registers
  always_ff @(posedge i_clk) begin
    if (i_rst) begin
      state_q <= S_IDLE;
      a_q <= '0;
      pend_q <= 1'b0;
      en_q <= 1'b0;
      drop_q <= 1'b0;
      perr_q <= 1'b0;
      words_q <= '0;
    end else begin
      state_q <= state_d;
      a_q <= a_d;
      pend_q <= pend_d;
      en_q <= en_d;
      drop_q <= drop_d;
      perr_q <= perr_d;
      words_q <= words_d;
    end
  end
  assign o_a = a_q;
  assign o_en = en_q;
  assign o_drop = drop_q;
  assign o_perr = perr_q;
  assign o_words = words_q;
endmodule

// File: tb/tb_nibble_deser.sv
// tb_nibble_deser: directed stimulus with a queue-based word model checked every cycle
module tb_nibble_deser;
  localparam int W = 4;
  localparam bit MSB_1ST = 1'b0;
  localparam int CNT_W = 8;
`ifdef NIBBLE_DESER_PARITY_EN
  localparam bit PAR = 1'b1;
`else
  localparam bit PAR = 1'b0;
`endif
  localparam int NB = PAR ? W + 1 : W;
  logic clk = 1'b0, rst = 1'b1, bit_valid = 1'b0, bit_in = 1'b0, sof = 1'b0, hold = 1'b0;
  logic o_bit_ready, o_en, o_drop, o_perr;
  logic [W-1:0] o_a;
  logic [CNT_W-1:0] o_words;
  int n_chk = 0, n_err = 0;
  bit chk_on = 1'b0;
  logic bits[$];
  logic m_pend = 1'b0, e_en = 1'b0, e_drop = 1'b0, e_perr = 1'b0;
  logic [W-1:0] e_a = '0;
  logic [CNT_W-1:0] e_words = '0;

  nibble_deser #(.W(W), .MSB_1ST(MSB_1ST), .CNT_W(CNT_W)) dut (
    .i_clk(clk), .i_rst(rst), .i_bit_valid(bit_valid), .o_bit_ready(o_bit_ready),
    .i_bit(bit_in), .i_sof(sof), .i_hold(hold), .o_a(o_a), .o_en(o_en),
    .o_drop(o_drop), .o_perr(o_perr), .o_words(o_words)
  );

  always #5 clk = ~clk;

  task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
    n_chk++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %h expected %h at %0t", nm, act, exp, $time);
    end
  endtask

  function automatic logic m_ready();
    return !(m_pend && bits.size() == NB - 1);
  endfunction

  // model: words are built from a queue of accepted bits, completed words wait for a strobe
  always @(posedge clk) begin
    logic acc;
    logic [W-1:0] w;
    if (rst) begin
      bits.delete();
      m_pend = 1'b0; e_a = '0; e_en = 1'b0; e_drop = 1'b0; e_perr = 1'b0; e_words = '0;
    end else begin
      acc = bit_valid && m_ready();
      e_en = m_pend && !hold;
      if (e_en) begin
        m_pend = 1'b0;
        e_words = e_words + 1'b1;
      end
      e_drop = 1'b0;
      e_perr = 1'b0;
      if (acc) begin
        if (sof && bits.size() != 0) begin
          bits.delete();
          e_drop = 1'b1;
        end
        bits.push_back(bit_in);
        if (bits.size() == NB) begin
          w = '0;
          for (int i = 0; i < W; i++) w[MSB_1ST ? W - 1 - i : i] = bits[i];
          if (PAR && ((^w) ^ bits[NB-1])) e_perr = 1'b1;
          else begin
            e_a = w;
            m_pend = 1'b1;
          end
          bits.delete();
        end
      end
    end
  end

  // compare every cycle once reset has been applied
  always @(negedge clk) begin
    if (chk_on) begin
      chk("a", 32'(o_a), 32'(e_a));
      chk("en", 32'(o_en), 32'(e_en));
      chk("drop", 32'(o_drop), 32'(e_drop));
      chk("perr", 32'(o_perr), 32'(e_perr));
      chk("words", 32'(o_words), 32'(e_words));
      chk("ready", 32'(o_bit_ready), 32'(m_ready()));
    end
  end

  task automatic cyc();
    @(posedge clk);
    @(negedge clk);
    #1;
  endtask

  task automatic idle(input int n);
    bit_valid = 1'b0;
    sof = 1'b0;
    for (int i = 0; i < n; i++) cyc();
  endtask

  task automatic send(input logic b, input logic s);
    int n = 0;
    logic r;
    bit_valid = 1'b1; bit_in = b; sof = s;
    do begin
      r = o_bit_ready;
      cyc();
      n++;
    end while (!r && n < 20);
    if (!r) begin
      n_chk++;
      n_err++;
      $display("FAIL send_timeout: got no accept expected accept at %0t", $time);
    end
    bit_valid = 1'b0;
    sof = 1'b0;
  endtask

  task automatic send_word(input logic [W-1:0] d, input bit par_good);
    for (int i = 0; i < W; i++) send(d[i], 1'b0);
    if (PAR) send((^d) ^ !par_good, 1'b0);
  endtask

  initial begin
    // reset with toggling bits
    bit_valid = 1'b1;
    bit_in = 1'b1;
    cyc();
    chk_on = 1'b1;
    bit_in = 1'b0;
    cyc();
    rst = 1'b0;
    bit_valid = 1'b0;
    chk("rst_a", 32'(o_a), 0);
    chk("rst_en", 32'(o_en), 0);
    chk("rst_words", 32'(o_words), 0);
    chk("rst_drop", 32'(o_drop), 0);
    chk("rst_perr", 32'(o_perr), 0);
    chk("rst_ready", 32'(o_bit_ready), 1);
    // single word 1,0,1,1
    send_word(4'b1101, 1'b1);
    chk("t2_a", 32'(o_a), 32'hD);
    chk("t2_en_early", 32'(o_en), 0);
    cyc();
    chk("t2_en", 32'(o_en), 1);
    chk("t2_words", 32'(o_words), 1);
    idle(2);
    // hold across completion, second word stalls on its last bit
    hold = 1'b1;
    send_word(4'b1101, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    if (PAR) send(1'b1, 1'b0);
    bit_valid = 1'b1;
    bit_in = PAR ? 1'b0 : 1'b1;
    chk("t3_ready", 32'(o_bit_ready), 0);
    cyc();
    chk("t3_ready_hold", 32'(o_bit_ready), 0);
    chk("t3_en_hold", 32'(o_en), 0);
    hold = 1'b0;
    cyc();
    chk("t3_en1", 32'(o_en), 1);
    chk("t3_a1", 32'(o_a), 32'hD);
    cyc();
    bit_valid = 1'b0;
    chk("t3_a2", 32'(o_a), 32'hC);
    cyc();
    chk("t3_en2", 32'(o_en), 1);
    chk("t3_words", 32'(o_words), 3);
    idle(2);
    // sof aborts a partial word
    send(1'b1, 1'b0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b1);
    chk("t4_drop", 32'(o_drop), 1);
    send(1'b1, 1'b0);
    chk("t4_drop_once", 32'(o_drop), 0);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    if (PAR) send(1'b0, 1'b0);
    chk("t4_a", 32'(o_a), 32'h6);
    idle(2);
    // sof on a fresh word, then sof on the would-be completing bit
    send(1'b1, 1'b1);
    send(1'b0, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    if (PAR) send(1'b0, 1'b0);
    idle(2);
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    send(1'b1, 1'b0);
    send(1'b1, 1'b1);
    idle(1);
    send_word(4'b0011, 1'b1);
    idle(2);
`ifdef NIBBLE_DESER_PARITY_EN
    // parity good then parity bad
    send_word(4'b1101, 1'b1);
    cyc();
    chk("t5_en", 32'(o_en), 1);
    chk("t5_a", 32'(o_a), 32'hD);
    idle(1);
    send_word(4'b0111, 1'b0);
    chk("t5_perr", 32'(o_perr), 1);
    cyc();
    chk("t5_no_en", 32'(o_en), 0);
    chk("t5_a_kept", 32'(o_a), 32'hD);
    idle(1);
`endif
    // counter wrap after 256 words
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    for (int k = 0; k < 256; k++) send_word(4'($urandom_range(0, 15)), 1'b1);
    idle(2);
    chk("t6_wrap", 32'(o_words), 0);
    // reset mid-word discards silently
    send(1'b1, 1'b0);
    send(1'b0, 1'b0);
    rst = 1'b1;
    cyc();
    rst = 1'b0;
    chk("t6_rst_drop", 32'(o_drop), 0);
    cyc();
    chk("t6_rst_en", 32'(o_en), 0);
    send_word(4'b1111, 1'b1);
    chk("t6_a", 32'(o_a), 32'hF);
    idle(2);
    chk("t6_words", 32'(o_words), 1);
    $display("Simulation finished: %0d checks, %0d errors", n_chk, n_err);
    $finish;
  end
endmodule
